prim_filter_ctr_multi: RTL and testbench
========================================

Name: prim_filter_ctr_multi

Overview:
- Multi-channel, counter-based debounce/glitch filter; successor to the fixed-depth shift-register filter.
- Per channel: filtered output changes only after the input holds a new value for a runtime-programmable number of cycles.
- Adds a per-channel bypass enable, a synchronous clear, and one-cycle rise/fall event pulses.
- Sits between input synchronisers (GPIO, pinmux wakeup, sysrst_ctrl key inputs) and consumer logic or interrupt detectors.

Parameters:
- NumChans, 4, number of independent filter channels (>=1).
- CntWidth, 16, width of the per-channel stability counter and of thresh_i (>=1).
- ResetValue, 1'b0, value loaded into sample and stored registers on reset/clear.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- clr_i  input  1  synchronous clear of all channels, same effect as reset.
- thresh_i  input  CntWidth  stability threshold, shared by all channels, used live each cycle.
- en_i  input  NumChans  per-channel enable: 1 = filtered output, 0 = raw bypass.
- filter_i  input  NumChans  raw (already synchronised) inputs.
- filter_o  output  NumChans  en_i[k] ? stored_q[k] : filter_i[k].
- rise_o  output  NumChans  one-cycle pulse after stored value goes 0->1, gated by en_i.
- fall_o  output  NumChans  one-cycle pulse after stored value goes 1->0, gated by en_i.

Behaviour:
- Per-channel state: sample_q (1b), cnt_q (CntWidth), stored_q (1b), prev_q (1b, stored value of previous cycle).
- Reset/clear (rst_i or clr_i high at an edge): sample_q, stored_q, prev_q <= ResetValue; cnt_q <= 0. Reset and clear take priority over every update, including mid-run; an in-progress run is discarded.
- Every non-reset edge: sample_q <= filter_i.
- cnt_d = (filter_i == sample_q) ? sat(cnt_q + 1) : 0, where sat holds at 2^CntWidth-1 without wrapping. cnt_q <= cnt_d.
- Update rule: if cnt_d >= thresh_i, then stored_q <= filter_i; otherwise stored_q holds.
  - Net effect: a new level must be present for thresh_i+1 consecutive sampled cycles.
  - thresh_i=0 gives a plain 1-cycle register.
  - thresh_i=3 matches the legacy 4-cycle filter.
  - The cycle immediately after reset/clear counts against sample_q=ResetValue.
- Comparison is unsigned. A thresh_i change takes effect in the same cycle; lowering it below a running cnt_q causes an update on the next edge if the input is still stable.
- Saturation: at thresh_i = 2^CntWidth-1 the counter saturates and updates every cycle thereafter while the input is stable. This is the intended maximum.
- Filter state always runs regardless of en_i, so re-enabling yields an already-settled value with no re-qualification.
- prev_q <= stored_q every non-reset edge.
- rise_o[k] = en_i[k] & stored_q[k] & ~prev_q[k]; fall_o[k] = en_i[k] & ~stored_q[k] & prev_q[k] (combinational from registers).
  - Pulses are asserted in the cycle after stored_q changes and last exactly one cycle.
  - No pulses are generated by reset/clear.
- Reset output values: filter_o = en_i ? ResetValue : filter_i; rise_o = fall_o = 0.
- Latency, enabled channel, input step at edge t, thresh_i=N: filter_o changes after edge t+N; the edge pulse is high during the following cycle.
- Glitch: any mismatch with sample_q zeroes the counter, and qualification restarts from the new level.
- Channels are fully independent; no cross-channel arbitration.

Decomposition:
- prim_filter_pkg:
  - default CntWidth constant.
  - function sat_inc(cnt) returning the saturating increment.
- Sub-module prim_filter_ctr_chan: one channel (sample/cnt/stored/prev registers plus edge logic), ports clk_i, rst_i, clr_i, thresh_i, en_i, filter_i, filter_o, rise_o, fall_o.
- Top level instantiates NumChans copies in a generate loop.

Test Plan:
- Reset/step: rst_i for 2 cycles with ResetValue=0 -> all filter_o=0, rise_o=fall_o=0. Then thresh_i=3, en_i=4'hF, ch0 held high from edge t -> filter_o[0]=1 after edge t+3, rise_o[0]=1 for exactly one cycle after that, no fall_o.
- Glitch rejection: thresh_i=3, ch1 pulses high for 3 cycles then low -> filter_o[1] stays 0, no pulses. A 4-cycle pulse -> rises after edge t+3, falls after 4 more stable-low cycles, with one fall_o pulse.
- thresh_i=0: ch2 toggles every cycle -> filter_o[2] equals filter_i delayed by 1 cycle. rise_o/fall_o alternate each cycle.
- Bypass: en_i[3]=0, ch3 toggling -> filter_o[3]=filter_i[3] combinationally, rise_o[3]=fall_o[3]=0. Re-enable after 10 stable-high cycles -> filter_o[3]=1 immediately, no pulse.
- Saturation/threshold change: CntWidth=4, thresh_i=15, input stable 20 cycles -> update after edge t+15, counter holds at 15. Lower thresh_i 10->2 mid-run at cnt=5 -> update on that edge.
- Clear mid-run: ch0 qualified high, clr_i pulsed for 1 cycle with input still high -> filter_o[0]=0, no fall_o; requalifies after thresh_i+1 cycles with a rise_o pulse.

Source files
------------

// File: rtl/prim_filter_ctr_multi_pkg.sv
// Shared constants and helpers for the counter-based debounce filter.
//   CntWidthDefault : default width of the per-channel stability counter
//   SatWidth        : width of the generic saturating-increment helper
//   sat_inc()       : increment that sticks at the all-ones value of a given width
package prim_filter_pkg;

  localparam int unsigned CntWidthDefault = 16;
  localparam int unsigned SatWidth        = 32;

  // Saturating increment; counter widths above SatWidth are not supported.
  function automatic logic [SatWidth-1:0] sat_inc(input logic [SatWidth-1:0] cnt,
                                                  input int unsigned         width);
    logic [SatWidth-1:0] max_val;
    if (width >= SatWidth) begin
      max_val = '1;
    end else begin
      max_val = (SatWidth'(1) << width) - SatWidth'(1);
    end
    return (cnt >= max_val) ? max_val : cnt + SatWidth'(1);
  endfunction

endpackage

// File: rtl/prim_filter_ctr_multi_if.sv
// Bus bundle for the multi-channel filter.
//   clr_i    : synchronous clear of all channels
//   thresh_i : shared stability threshold
//   en_i     : per-channel enable (0 = raw bypass)
//   filter_i : raw synchronised inputs
//   filter_o : filtered (or bypassed) outputs
//   rise_o   : one-cycle rising-edge events
//   fall_o   : one-cycle falling-edge events
interface prim_filter_ctr_multi_if #(
  parameter int unsigned NumChans = 4,
  parameter int unsigned CntWidth = 16
);

  logic                clr_i;
  logic [CntWidth-1:0] thresh_i;
  logic [NumChans-1:0] en_i;
  logic [NumChans-1:0] filter_i;
  logic [NumChans-1:0] filter_o;
  logic [NumChans-1:0] rise_o;
  logic [NumChans-1:0] fall_o;

  modport master (
    output clr_i, thresh_i, en_i, filter_i,
    input  filter_o, rise_o, fall_o
  );

  modport slave (
    input  clr_i, thresh_i, en_i, filter_i,
    output filter_o, rise_o, fall_o
  );

endinterface

// File: rtl/prim_filter_ctr_multi_chan.sv
// One debounce channel: input sample, stability counter, stored level and
// previous stored level for edge events.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   clr_i              : synchronous clear, same effect as reset
//   thresh_i           : stability threshold (live)
//   en_i               : 1 = filtered output, 0 = raw bypass
//   filter_i           : raw input
//   filter_o           : filtered or bypassed output
//   rise_o, fall_o     : edge events on the stored level, gated by en_i
module prim_filter_ctr_chan
  import prim_filter_pkg::*;
#(
  parameter int unsigned CntWidth   = CntWidthDefault,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                en_i,
  input  logic                filter_i,
  output logic                filter_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic                sample_q;
  logic                stored_q;
  logic                stored_d;
  logic                prev_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;

  // Count consecutive matching samples; any mismatch restarts qualification.
  always_comb begin
    cnt_d    = '0;
    stored_d = stored_q;
    if (filter_i == sample_q) begin
      cnt_d = CntWidth'(sat_inc(SatWidth'(cnt_q), CntWidth));
    end
    if (cnt_d >= thresh_i) begin
      stored_d = filter_i;
    end
  end

  // Filter state runs regardless of en_i so re-enabling needs no re-qualification.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      sample_q <= ResetValue;
      stored_q <= ResetValue;
      prev_q   <= ResetValue;
      cnt_q    <= '0;
    end else begin
      sample_q <= filter_i;
      stored_q <= stored_d;
      prev_q   <= stored_q;
      cnt_q    <= cnt_d;
    end
  end

  assign filter_o = en_i ? stored_q : filter_i;
  assign rise_o   = en_i &  stored_q & ~prev_q;
  assign fall_o   = en_i & ~stored_q &  prev_q;

endmodule

// File: rtl/prim_filter_ctr_multi.sv
// Multi-channel counter-based debounce/glitch filter with bypass, clear and
// rise/fall events.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : slave side of prim_filter_ctr_multi_if (clear, threshold, enables,
//           raw inputs, filtered outputs and edge events)
module prim_filter_ctr_multi
  import prim_filter_pkg::*;
#(
  parameter int unsigned NumChans   = 4,
  parameter int unsigned CntWidth   = CntWidthDefault,
  parameter logic        ResetValue = 1'b0
) (
  input logic                     clk_i,
  input logic                     rst_i,
  prim_filter_ctr_multi_if.slave  bus
);

  logic [NumChans-1:0] filt;
  logic [NumChans-1:0] rise;
  logic [NumChans-1:0] fall;

  // Independent channels sharing clear and threshold.
  for (genvar k = 0; k < NumChans; k++) begin : g_chan
    prim_filter_ctr_chan #(
      .CntWidth   (CntWidth),
      .ResetValue (ResetValue)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (bus.clr_i),
      .thresh_i (bus.thresh_i),
      .en_i     (bus.en_i[k]),
      .filter_i (bus.filter_i[k]),
      .filter_o (filt[k]),
      .rise_o   (rise[k]),
      .fall_o   (fall[k])
    );
  end

  assign bus.filter_o = filt;
  assign bus.rise_o   = rise;
  assign bus.fall_o   = fall;

endmodule

// File: tb/tb_prim_filter_ctr_multi.sv
// Self-checking bench for prim_filter_ctr_multi: directed scenarios plus a
// randomized run against a history-based reference model.
module tb_prim_filter_ctr_multi;

  localparam int unsigned NCh = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prim_filter_ctr_multi_if #(.NumChans(NCh), .CntWidth(16)) bus ();
  prim_filter_ctr_multi_if #(.NumChans(1),   .CntWidth(4))  sbus ();

  prim_filter_ctr_multi #(.NumChans(NCh), .CntWidth(16), .ResetValue(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  prim_filter_ctr_multi #(.NumChans(1), .CntWidth(4), .ResetValue(1'b0)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (sbus)
  );

  // Reference model: full sample history since reset/clear. The counter value
  // is the length of the trailing run of identical samples minus one.
  bit   hist [NCh][$];
  logic [NCh-1:0] st_m = '0;
  logic [NCh-1:0] pv_m = '0;

  always @(posedge clk) begin
    for (int k = 0; k < NCh; k++) begin
      if (rst || bus.clr_i) begin
        hist[k].delete();
        hist[k].push_back(1'b0);
        st_m[k] = 1'b0;
        pv_m[k] = 1'b0;
      end else begin
        int run;
        bit stop;
        pv_m[k] = st_m[k];
        hist[k].push_back(bus.filter_i[k]);
        if (hist[k].size() > 48) void'(hist[k].pop_front());
        run  = 0;
        stop = 0;
        for (int j = hist[k].size() - 1; j >= 0; j--) begin
          if (!stop && hist[k][j] == bus.filter_i[k]) run++;
          else stop = 1;
        end
        if (longint'(run - 1) >= longint'(bus.thresh_i)) st_m[k] = bus.filter_i[k];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst           = 1'b1;
    bus.clr_i     = 1'b0;
    sbus.clr_i    = 1'b0;
    bus.filter_i  = '0;
    sbus.filter_i = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.clr_i     = 1'b0;
    bus.thresh_i  = 16'd3;
    bus.en_i      = 4'b0101;
    bus.filter_i  = 4'b1010;
    sbus.clr_i    = 1'b0;
    sbus.thresh_i = 4'd0;
    sbus.en_i     = 1'b1;
    sbus.filter_i = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (bus.filter_o !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_bypass: got %b want %b", bus.filter_o, 4'b1010);
    end
    bus.en_i     = 4'hF;
    bus.filter_i = 4'h0;
    #1;
    n_cmp++;
    if (bus.filter_o !== 4'h0 || bus.rise_o !== 4'h0 || bus.fall_o !== 4'h0) begin
      n_err++;
      $display("FAIL reset_state: got f=%b r=%b fl=%b want 0/0/0",
               bus.filter_o, bus.rise_o, bus.fall_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_step();
    reset_dut();
    bus.thresh_i = 16'd3;
    bus.en_i     = 4'hF;
    bus.filter_i = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      cyc();
      n_cmp++;
      if (bus.filter_o[0] !== (i >= 3) || bus.rise_o[0] !== (i == 3) || bus.fall_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL step i=%0d: got f=%b r=%b fl=%b want f=%b r=%b fl=0", i,
                 bus.filter_o[0], bus.rise_o[0], bus.fall_o[0], i >= 3, i == 3);
      end
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    bus.thresh_i = 16'd3;
    bus.en_i     = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus.filter_i[1] = (i < 3);
      cyc();
      n_cmp++;
      if (bus.filter_o[1] !== 1'b0 || bus.rise_o[1] !== 1'b0 || bus.fall_o[1] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch3 i=%0d: got f=%b r=%b fl=%b want 0/0/0", i,
                 bus.filter_o[1], bus.rise_o[1], bus.fall_o[1]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      bus.filter_i[1] = (i < 4);
      cyc();
      n_cmp++;
      if (bus.filter_o[1] !== (i >= 3 && i < 7) || bus.rise_o[1] !== (i == 3) ||
          bus.fall_o[1] !== (i == 7)) begin
        n_err++;
        $display("FAIL pulse4 i=%0d: got f=%b r=%b fl=%b want f=%b r=%b fl=%b", i,
                 bus.filter_o[1], bus.rise_o[1], bus.fall_o[1],
                 i >= 3 && i < 7, i == 3, i == 7);
      end
    end
  endtask

  task automatic test_thresh0();
    reset_dut();
    bus.thresh_i = 16'd0;
    bus.en_i     = 4'hF;
    for (int i = 0; i < 8; i++) begin
      logic v;
      v = (i % 2 == 0);
      bus.filter_i[2] = v;
      cyc();
      n_cmp++;
      if (bus.filter_o[2] !== v || bus.rise_o[2] !== v || bus.fall_o[2] !== (i > 0 && !v)) begin
        n_err++;
        $display("FAIL thresh0 i=%0d: got f=%b r=%b fl=%b want f=%b r=%b fl=%b", i,
                 bus.filter_o[2], bus.rise_o[2], bus.fall_o[2], v, v, i > 0 && !v);
      end
    end
  endtask

  task automatic test_bypass();
    reset_dut();
    bus.thresh_i = 16'd3;
    bus.en_i     = 4'b0111;
    for (int i = 0; i < 8; i++) begin
      bus.filter_i[3] = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (bus.filter_o[3] !== bus.filter_i[3] || bus.rise_o[3] !== 1'b0 || bus.fall_o[3] !== 1'b0) begin
        n_err++;
        $display("FAIL bypass i=%0d: got f=%b r=%b fl=%b want f=%b r=0 fl=0", i,
                 bus.filter_o[3], bus.rise_o[3], bus.fall_o[3], bus.filter_i[3]);
      end
      cyc();
    end
    bus.filter_i[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (bus.rise_o[3] !== 1'b0 || bus.fall_o[3] !== 1'b0) begin
        n_err++;
        $display("FAIL bypass_hold i=%0d: got r=%b fl=%b want 0/0", i,
                 bus.rise_o[3], bus.fall_o[3]);
      end
    end
    bus.en_i[3] = 1'b1;
    #1;
    n_cmp++;
    if (bus.filter_o[3] !== 1'b1 || bus.rise_o[3] !== 1'b0 || bus.fall_o[3] !== 1'b0) begin
      n_err++;
      $display("FAIL reenable: got f=%b r=%b fl=%b want 1/0/0",
               bus.filter_o[3], bus.rise_o[3], bus.fall_o[3]);
    end
  endtask

  task automatic test_clear();
    reset_dut();
    bus.thresh_i = 16'd3;
    bus.en_i     = 4'hF;
    bus.filter_i = 4'b0001;
    for (int i = 0; i < 6; i++) cyc();
    n_cmp++;
    if (bus.filter_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL clear_pre: got %b want 1", bus.filter_o[0]);
    end
    bus.clr_i = 1'b1;
    cyc();
    bus.clr_i = 1'b0;
    n_cmp++;
    if (bus.filter_o[0] !== 1'b0 || bus.fall_o[0] !== 1'b0 || bus.rise_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_now: got f=%b r=%b fl=%b want 0/0/0",
               bus.filter_o[0], bus.rise_o[0], bus.fall_o[0]);
    end
    for (int i = 1; i < 7; i++) begin
      cyc();
      n_cmp++;
      if (bus.filter_o[0] !== (i >= 4) || bus.rise_o[0] !== (i == 4) || bus.fall_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL clear_requal i=%0d: got f=%b r=%b fl=%b want f=%b r=%b fl=0", i,
                 bus.filter_o[0], bus.rise_o[0], bus.fall_o[0], i >= 4, i == 4);
      end
    end
  endtask

  task automatic test_saturation();
    reset_dut();
    sbus.thresh_i = 4'd15;
    sbus.en_i     = 1'b1;
    sbus.filter_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_cmp++;
      if (sbus.filter_o[0] !== (i >= 15) || sbus.rise_o[0] !== (i == 15) || sbus.fall_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL sat i=%0d: got f=%b r=%b fl=%b want f=%b r=%b fl=0", i,
                 sbus.filter_o[0], sbus.rise_o[0], sbus.fall_o[0], i >= 15, i == 15);
      end
    end
    reset_dut();
    sbus.filter_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sbus.thresh_i = (i >= 5) ? 4'd2 : 4'd10;
      cyc();
      n_cmp++;
      if (sbus.filter_o[0] !== (i >= 5) || sbus.rise_o[0] !== (i == 5)) begin
        n_err++;
        $display("FAIL thresh_lower i=%0d: got f=%b r=%b want f=%b r=%b", i,
                 sbus.filter_o[0], sbus.rise_o[0], i >= 5, i == 5);
      end
    end
  endtask

  task automatic test_random();
    logic [NCh-1:0] ef;
    logic [NCh-1:0] er;
    logic [NCh-1:0] efl;
    reset_dut();
    bus.thresh_i = 16'd2;
    bus.en_i     = 4'hF;
    for (int i = 0; i < 300; i++) begin
      bus.clr_i = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) bus.thresh_i = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) bus.en_i = 4'($urandom_range(0, 15));
      for (int k = 0; k < NCh; k++) begin
        if ($urandom_range(0, 3) == 0) bus.filter_i[k] = ~bus.filter_i[k];
      end
      cyc();
      ef  = (bus.en_i & st_m) | (~bus.en_i & bus.filter_i);
      er  = bus.en_i & st_m & ~pv_m;
      efl = bus.en_i & ~st_m & pv_m;
      n_cmp++;
      if (bus.filter_o !== ef || bus.rise_o !== er || bus.fall_o !== efl) begin
        n_err++;
        $display("FAIL random i=%0d: got f=%b r=%b fl=%b want f=%b r=%b fl=%b", i,
                 bus.filter_o, bus.rise_o, bus.fall_o, ef, er, efl);
      end
    end
    bus.clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_thresh0();
    test_bypass();
    test_clear();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
